// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides. Shifts are iterative by
// default; define ALU_EXEC_FAST_SHIFT_EN to use a single-cycle barrel shifter instead.
package riscv_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ops_t;
endpackage

module alu_exec_unit
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_ops_t        alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    alu_ops_t        op_q, op_d;

    logic [SW-1:0]   shamt;
    logic [SW-1:0]   step;
    logic [XLEN-1:0] next_val;
    logic            unused_src_b;

    assign shamt        = src_b[SW-1:0];
    assign unused_src_b = ^src_b[XLEN-1:SW];

    function automatic logic is_shift(input alu_ops_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic logic [XLEN-1:0] alu_compute(input alu_ops_t op,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        a_s = a;
        b_s = b;
        case (op)
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
            default:  return a + b;
        endcase
    endfunction

    // SRA keeps the sign bit in place every step, so re-shifting the partial value
    // arithmetically keeps filling with the original bit XLEN-1.
    function automatic logic [XLEN-1:0] shift_by(input alu_ops_t op,
                                                 input logic [XLEN-1:0] v,
                                                 input logic [SW-1:0] amt);
        logic signed [XLEN-1:0] v_s;
        v_s = v;
        case (op)
            ALU_SLL: return v << amt;
            ALU_SRL: return v >> amt;
            default: return v_s >>> amt;
        endcase
    endfunction

    function automatic logic [SW-1:0] step_amt(input logic [SW-1:0] remaining);
        return (remaining < STEP) ? remaining : STEP;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
            op_q     <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        step     = '0;
        next_val = '0;
        if (flush) begin
            state_d  = IDLE;
            result_d = '0;
            zero_d   = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d = alu_ctrl;
                        if (is_shift(alu_ctrl)) begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
                            next_val = shift_by(alu_ctrl, src_a, shamt);
                            cnt_d    = '0;
                            state_d  = DONE;
`else
                            step     = step_amt(shamt);
                            next_val = shift_by(alu_ctrl, src_a, step);
                            cnt_d    = shamt - step;
                            state_d  = (cnt_d != '0) ? SHIFT : DONE;
`endif
                        end else begin
                            next_val = alu_compute(alu_ctrl, src_a, src_b);
                            state_d  = DONE;
                        end
                        result_d = next_val;
                        zero_d   = (next_val == '0);
                    end
                end
                SHIFT: begin
                    step     = step_amt(cnt_q);
                    next_val = shift_by(op_q, result_q, step);
                    cnt_d    = cnt_q - step;
                    result_d = next_val;
                    zero_d   = (next_val == '0);
                    if (cnt_d == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !flush;
        out_valid = (state_q == DONE);
        result    = result_q;
        zero      = zero_q;
    end

endmodule
